mem_access_stage: RTL and testbench

- MEM pipeline stage directly downstream of the EX/MEM register. It consumes the EX/MEM register's outputs, performs the data-memory access and registers the results into the MEM/WB boundary for the write-back stage.
- Data memory is word-organised with a configurable access latency.
- While a multi-cycle access is in flight, the stage asserts `stall_out` to upstream and inserts bubbles downstream.

---
 rtl/mem_stage_pkg.sv | 43 ++++
 rtl/mem_access_stage_data_mem.sv | 32 +++
 rtl/mem_access_stage.sv | 136 +++++++++++++
 tb/tb_mem_access_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// ============================================================================
// mem_stage_pkg : shared types, bubble constants and address check for MEM stage
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic        wb;
        logic        rd;
        logic        wr;
        logic        m2r;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [4:0]  dst;
    } ex_mem_t;

    // load_ok gates the RAM's registered read port onto mem_read_data_out
    typedef struct packed {
        logic        wb;
        logic        m2r;
        logic [31:0] alu;
        logic [4:0]  dst;
        logic        err;
        logic        load_ok;
    } mem_wb_t;

    localparam ex_mem_t c_ex_mem_nop    = '0;
    localparam mem_wb_t c_mem_wb_bubble = '0;

    function automatic logic addr_legal(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && ((addr >> 2) < depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_stage_data_mem.sv
// ============================================================================
// data_mem : synchronous single-port DEPTH x 32 RAM, registered read-before-write
// Rev 1.0
// ============================================================================
`default_nettype none

module data_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] index_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        rdata_q <= mem_q[index_i];
        if (we_i) begin
            mem_q[index_i] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// mem_access_stage : MEM pipeline stage with configurable-latency data memory
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem2reg_in,
    input  logic [31:0] mem_write_data_in,
    input  logic [31:0] ALU_result_in,
    input  logic [4:0]  dst_addr_in,
    output logic        stall_out,
    output logic        wb_out,
    output logic        mem2reg_out,
    output logic [31:0] mem_read_data_out,
    output logic [31:0] ALU_result_out,
    output logic [4:0]  dst_addr_out,
    output logic        addr_err_out
);

    localparam int         ADDR_W = $clog2(DEPTH);
    localparam logic [3:0] c_lat  = 4'(MEM_LAT);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    ex_mem_t     cap_q, cap_d;
    mem_wb_t     out_q, out_d;

    ex_mem_t     w_in;
    ex_mem_t     w_sel;
    logic        w_complete;
    logic        w_legal;
    logic        w_we;
    logic [31:0] w_rdata;

    assign w_in = '{wb: wb_in, rd: mem_read_in, wr: mem_write_in, m2r: mem2reg_in,
                    wdata: mem_write_data_in, addr: ALU_result_in, dst: dst_addr_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            cap_q   <= c_ex_mem_nop;
            out_q   <= c_mem_wb_bubble;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        out_d      = c_mem_wb_bubble;
        stall_out  = 1'b0;
        w_complete = 1'b0;
        w_sel      = w_in;

        case (state_q)
            S_IDLE: begin
                if ((w_in.rd || w_in.wr) && (MEM_LAT != 0)) begin
                    stall_out = 1'b1;
                    cap_d     = w_in;
                    cnt_d     = 4'd1;
                    state_d   = S_WAIT;
                end else begin
                    w_complete = 1'b1;
                end
            end
            S_WAIT: begin
                // the captured op drives the RAM; live inputs are ignored here
                w_sel = cap_q;
                if (cnt_q < c_lat) begin
                    stall_out = 1'b1;
                    cnt_d     = cnt_q + 4'd1;
                end else begin
                    w_complete = 1'b1;
                    cnt_d      = 4'd0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        w_legal = addr_legal(w_sel.addr, unsigned'(DEPTH));

        if (w_complete) begin
            out_d.wb      = w_sel.wb;
            out_d.m2r     = w_sel.m2r;
            out_d.alu     = w_sel.addr;
            out_d.dst     = w_sel.dst;
            out_d.err     = (w_sel.rd || w_sel.wr) && !w_legal;
            out_d.load_ok = w_sel.rd && w_legal;
        end
    end

    // rst_n gate keeps a clock edge during reset from committing a store
    assign w_we = w_complete && w_sel.wr && w_legal && rst_n;

    data_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk     (clk),
        .we_i    (w_we),
        .index_i (w_sel.addr[ADDR_W+1:2]),
        .wdata_i (w_sel.wdata),
        .rdata_o (w_rdata)
    );

    assign wb_out            = out_q.wb;
    assign mem2reg_out       = out_q.m2r;
    assign ALU_result_out    = out_q.alu;
    assign dst_addr_out      = out_q.dst;
    assign addr_err_out      = out_q.err;
    assign mem_read_data_out = out_q.load_ok ? w_rdata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// tb_mem_access_stage : three stage instances (MEM_LAT 0/2/3) against a word-array model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

    localparam int DEPTH = 256;
    localparam int NDUT  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wb_i   [NDUT];
    logic        rd_i   [NDUT];
    logic        wr_i   [NDUT];
    logic        m2r_i  [NDUT];
    logic [31:0] wd_i   [NDUT];
    logic [31:0] addr_i [NDUT];
    logic [4:0]  dst_i  [NDUT];
    logic        stall_o[NDUT];
    logic        wb_o   [NDUT];
    logic        m2r_o  [NDUT];
    logic [31:0] rdata_o[NDUT];
    logic [31:0] alu_o  [NDUT];
    logic [4:0]  dst_o  [NDUT];
    logic        err_o  [NDUT];

    logic [31:0] mdl [NDUT][DEPTH];
    int checks   = 0;
    int failures = 0;

    mem_access_stage #(.DEPTH(DEPTH), .MEM_LAT(0)) u_dut_l0 (
        .clk(clk), .rst_n(rst_n), .wb_in(wb_i[0]), .mem_read_in(rd_i[0]),
        .mem_write_in(wr_i[0]), .mem2reg_in(m2r_i[0]), .mem_write_data_in(wd_i[0]),
        .ALU_result_in(addr_i[0]), .dst_addr_in(dst_i[0]), .stall_out(stall_o[0]),
        .wb_out(wb_o[0]), .mem2reg_out(m2r_o[0]), .mem_read_data_out(rdata_o[0]),
        .ALU_result_out(alu_o[0]), .dst_addr_out(dst_o[0]), .addr_err_out(err_o[0]));

    mem_access_stage #(.DEPTH(DEPTH), .MEM_LAT(2)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n), .wb_in(wb_i[1]), .mem_read_in(rd_i[1]),
        .mem_write_in(wr_i[1]), .mem2reg_in(m2r_i[1]), .mem_write_data_in(wd_i[1]),
        .ALU_result_in(addr_i[1]), .dst_addr_in(dst_i[1]), .stall_out(stall_o[1]),
        .wb_out(wb_o[1]), .mem2reg_out(m2r_o[1]), .mem_read_data_out(rdata_o[1]),
        .ALU_result_out(alu_o[1]), .dst_addr_out(dst_o[1]), .addr_err_out(err_o[1]));

    mem_access_stage #(.DEPTH(DEPTH), .MEM_LAT(3)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n), .wb_in(wb_i[2]), .mem_read_in(rd_i[2]),
        .mem_write_in(wr_i[2]), .mem2reg_in(m2r_i[2]), .mem_write_data_in(wd_i[2]),
        .ALU_result_in(addr_i[2]), .dst_addr_in(dst_i[2]), .stall_out(stall_o[2]),
        .wb_out(wb_o[2]), .mem2reg_out(m2r_o[2]), .mem_read_data_out(rdata_o[2]),
        .ALU_result_out(alu_o[2]), .dst_addr_out(dst_o[2]), .addr_err_out(err_o[2]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=0x%08h expected=0x%08h", tag, d, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int d, input logic ewb, input logic em2r,
                              input logic [31:0] erd, input logic [31:0] ealu,
                              input logic [4:0] edst, input logic eerr);
        check({tag, ".wb"},    d, 32'(wb_o[d]),  32'(ewb));
        check({tag, ".m2r"},   d, 32'(m2r_o[d]), 32'(em2r));
        check({tag, ".rdata"}, d, rdata_o[d],    erd);
        check({tag, ".alu"},   d, alu_o[d],      ealu);
        check({tag, ".dst"},   d, 32'(dst_o[d]), 32'(edst));
        check({tag, ".err"},   d, 32'(err_o[d]), 32'(eerr));
    endtask

    task automatic idle_inputs(input int d);
        wb_i[d] = 1'b0; rd_i[d] = 1'b0; wr_i[d] = 1'b0; m2r_i[d] = 1'b0;
        wd_i[d] = 32'h0; addr_i[d] = 32'h0; dst_i[d] = 5'd0;
    endtask

    // Called at a falling edge; presents one instruction and checks every cycle until it retires.
    task automatic run_op(input int d, input logic wb, input logic rd, input logic wr, input logic m2r,
                          input logic [31:0] wdata, input logic [31:0] addr, input logic [4:0] dst,
                          input bit garble);
        int          lat;
        logic        legal;
        logic        exp_err;
        logic [31:0] exp_rd;
        legal   = (addr % 4 == 0) && (addr < 32'(4 * DEPTH));
        lat     = (rd || wr) ? lat_of(d) : 0;
        exp_err = (rd || wr) && !legal;
        exp_rd  = (rd && legal) ? mdl[d][addr / 4] : 32'h0;
        if (wr && legal) mdl[d][addr / 4] = wdata;
        wb_i[d] = wb; rd_i[d] = rd; wr_i[d] = wr; m2r_i[d] = m2r;
        wd_i[d] = wdata; addr_i[d] = addr; dst_i[d] = dst;
        for (int c = 0; c <= lat; c++) begin
            #1;
            check("stall", d, 32'(stall_o[d]), 32'(c < lat));
            @(posedge clk);
            if (garble && c < lat) begin
                #1;
                wb_i[d] = 1'($urandom); rd_i[d] = 1'($urandom); wr_i[d] = 1'($urandom);
                m2r_i[d] = 1'($urandom); wd_i[d] = $urandom; addr_i[d] = $urandom;
                dst_i[d] = 5'($urandom);
            end
            @(negedge clk);
            if (c < lat) check_outs("bubble", d, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
            else         check_outs("result", d, wb, m2r, exp_rd, addr, dst, exp_err);
        end
        idle_inputs(d);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7)      return 32'($urandom_range(0, DEPTH - 1)) * 4;
        else if (r < 9) return 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        else            return 32'(4 * DEPTH) + 32'($urandom_range(0, 4000));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < NDUT; d++) idle_inputs(d);
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check("rst_stall", d, 32'(stall_o[d]), 32'h0);
            check_outs("rst", d, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Give every word a known value so any later load has a defined expectation.
        for (int d = 0; d < NDUT; d++)
            for (int i = 0; i < DEPTH; i++)
                run_op(d, 1'b0, 1'b0, 1'b1, 1'b0, $urandom, 32'(i * 4), 5'd0, 1'b1);

        // Single-cycle store then load.
        run_op(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h10, 5'd0, 1'b0);
        run_op(0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h10, 5'd5, 1'b0);

        // Two-cycle latency load, inputs held stable.
        run_op(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h10, 5'd0, 1'b0);
        run_op(1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h10, 5'd5, 1'b0);

        // Non-memory pass-through.
        for (int d = 0; d < NDUT; d++)
            run_op(d, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1234, 5'd7, 1'b0);

        // Misaligned store is dropped; out-of-range load returns zero.
        for (int d = 0; d < NDUT; d++) begin
            run_op(d, 1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 32'h13, 5'd0, 1'b1);
            run_op(d, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h10, 5'd3, 1'b1);
            run_op(d, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'(4 * DEPTH), 5'd9, 1'b1);
        end

        // Reset during the second wait cycle of a MEM_LAT=3 store abandons the store.
        wb_i[2] = 1'b0; rd_i[2] = 1'b0; wr_i[2] = 1'b1; m2r_i[2] = 1'b0;
        wd_i[2] = 32'h55; addr_i[2] = 32'h20; dst_i[2] = 5'd0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_outs("midrst", 2, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        idle_inputs(2);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_stall", 2, 32'(stall_o[2]), 32'h0);
        @(negedge clk);
        run_op(2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h20, 5'd4, 1'b0);

        // Read and write together: old word returned, new word stored.
        for (int d = 0; d < NDUT; d++) begin
            run_op(d, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11, 32'h08, 5'd0, 1'b0);
            run_op(d, 1'b1, 1'b1, 1'b1, 1'b1, 32'h22, 32'h08, 5'd2, 1'b1);
            run_op(d, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h08, 5'd2, 1'b0);
        end

        // Randomised mix of loads, stores, both, ALU ops and bad addresses.
        for (int n = 0; n < 300; n++) begin
            int d;
            int unsigned k;
            logic rd, wr;
            d  = int'($urandom_range(0, NDUT - 1));
            k  = $urandom_range(0, 9);
            rd = (k < 4) || (k == 8);
            wr = (k >= 4 && k < 7) || (k == 8);
            run_op(d, 1'($urandom), rd, wr, 1'($urandom), $urandom,
                   (rd || wr) ? rand_addr() : $urandom, 5'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
